// File: rtl/lisp_eval_core_if.sv
// Heap read port between the evaluator (master) and the heap memory (slave).
// One request is outstanding at a time; rdata is valid while ready is high.
interface lisp_eval_core_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 12
) ();
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [WORD_W-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ready, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ready, mem_rdata);
endinterface

// File: rtl/lisp_eval_core.sv
// Tagged-expression evaluator: a number, or a primitive application whose
// arguments are number pointers, walked over the heap with a watchdog per read.
module lisp_eval_core #(
  parameter int WORD_W   = 16,
  parameter int TAG_W    = 3,
  parameter int ADDR_W   = 12,
  parameter int MAX_ARGS = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] expr_in,
  lisp_eval_core_if.master  mem,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] val,
  output logic [3:0]        error,
  output logic [3:0]        state_dbg
);

  if (1 + TAG_W + ADDR_W != WORD_W) begin : g_bad_field_layout
    $error("lisp_eval_core: 1+TAG_W+ADDR_W must equal WORD_W");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_MEM_WAIT, S_EVAL_CONST, S_APPLY,
    S_LIST_STEP, S_ARG_PTR, S_ACCUM, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_OR} op_t;

  localparam logic [TAG_W-1:0] TAG_NUMBER = TAG_W'(0);
  localparam logic [TAG_W-1:0] TAG_CONS   = TAG_W'(1);
  localparam logic [TAG_W-1:0] TAG_PRIM   = TAG_W'(2);
  localparam logic [TAG_W-1:0] TAG_NIL    = TAG_W'(3);

  localparam logic [3:0] ERR_EXPR_TAG = 4'd1;
  localparam logic [3:0] ERR_NOT_PRIM = 4'd2;
  localparam logic [3:0] ERR_ARGC     = 4'd3;
  localparam logic [3:0] ERR_BAD_LIST = 4'd4;
  localparam logic [3:0] ERR_TIMEOUT  = 4'd5;
  localparam logic [3:0] ERR_OPCODE   = 4'd6;

  localparam int CNT_W = $clog2(MAX_ARGS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] MAX_ARGS_C = CNT_W'(MAX_ARGS);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  function automatic logic [TAG_W-1:0] tag_of(input logic [WORD_W-1:0] w);
    return w[WORD_W-2 -: TAG_W];
  endfunction

  function automatic logic [ADDR_W-1:0] ptr_of(input logic [WORD_W-1:0] w);
    return w[ADDR_W-1:0];
  endfunction

  state_t            r_state, r_cont;
  op_t               r_op;
  logic [WORD_W-1:0] r_expr, r_rdata, r_acc, r_val;
  logic [ADDR_W-1:0] r_list, r_mem_addr;
  logic [CNT_W-1:0]  r_argc;
  logic [TMO_W-1:0]  r_tmo;
  logic [3:0]        r_error;
  logic              r_mem_req, r_done;
  logic [WORD_W-1:0] w_acc_next;

  // The first argument seeds the accumulator; later ones fold left.
  always_comb begin
    // NOTE: default first so no path through the block leaves w_acc_next unassigned (no latch).
    w_acc_next = r_rdata;
    if (r_argc != '0) begin
      unique case (r_op)
        OP_ADD: w_acc_next = r_acc + r_rdata;
        OP_SUB: w_acc_next = r_acc - r_rdata;
        OP_AND: w_acc_next = r_acc & r_rdata;
        OP_OR:  w_acc_next = r_acc | r_rdata;
        default: w_acc_next = r_rdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cont     <= S_IDLE;
      r_op       <= OP_ADD;
      r_expr     <= '0;
      r_rdata    <= '0;
      r_acc      <= '0;
      r_val      <= '0;
      r_list     <= '0;
      r_mem_addr <= '0;
      r_argc     <= '0;
      r_tmo      <= '0;
      r_error    <= '0;
      r_mem_req  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here turn req/done into one-cycle pulses unless a state re-asserts them.
      r_mem_req <= 1'b0;
      r_done    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_expr  <= expr_in;
            r_val   <= '0;
            r_error <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (tag_of(r_expr) == TAG_NUMBER || tag_of(r_expr) == TAG_CONS) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= ptr_of(r_expr);
            r_cont     <= (tag_of(r_expr) == TAG_NUMBER) ? S_EVAL_CONST : S_APPLY;
            r_tmo      <= '0;
            r_state    <= S_MEM_WAIT;
          end else begin
            r_error <= ERR_EXPR_TAG;
            r_done  <= 1'b1;
            r_state <= S_ERROR;
          end
        end
        S_MEM_WAIT: begin
          if (mem.mem_ready) begin
            r_rdata <= mem.mem_rdata;
            r_state <= r_cont;
          end else if (TIMEOUT != 0 && r_tmo == TMO_LAST) begin
            r_error <= ERR_TIMEOUT;
            r_done  <= 1'b1;
            r_state <= S_ERROR;
          end else if (TIMEOUT != 0) begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_EVAL_CONST: begin
          r_val   <= r_rdata;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_APPLY: begin
          if (tag_of(r_rdata) != TAG_PRIM) begin
            r_error <= ERR_NOT_PRIM;
            r_done  <= 1'b1;
            r_state <= S_ERROR;
          end else if (ptr_of(r_rdata) > ADDR_W'(3)) begin
            r_error <= ERR_OPCODE;
            r_done  <= 1'b1;
            r_state <= S_ERROR;
          end else begin
            r_op       <= op_t'(r_rdata[1:0]);
            r_argc     <= '0;
            r_mem_req  <= 1'b1;
            r_mem_addr <= ptr_of(r_expr) + 1'b1;
            r_cont     <= S_LIST_STEP;
            r_tmo      <= '0;
            r_state    <= S_MEM_WAIT;
          end
        end
        S_LIST_STEP: begin
          if (tag_of(r_rdata) == TAG_NIL) begin
            if (r_argc == '0) begin
              r_error <= ERR_ARGC;
              r_state <= S_ERROR;
            end else begin
              r_val   <= r_acc;
              r_state <= S_DONE;
            end
            r_done <= 1'b1;
          end else if (tag_of(r_rdata) == TAG_CONS) begin
            r_list     <= ptr_of(r_rdata);
            r_mem_req  <= 1'b1;
            r_mem_addr <= ptr_of(r_rdata);
            r_cont     <= S_ARG_PTR;
            r_tmo      <= '0;
            r_state    <= S_MEM_WAIT;
          end else begin
            r_error <= ERR_BAD_LIST;
            r_done  <= 1'b1;
            r_state <= S_ERROR;
          end
        end
        S_ARG_PTR: begin
          if (tag_of(r_rdata) != TAG_NUMBER) begin
            r_error <= ERR_BAD_LIST;
            r_done  <= 1'b1;
            r_state <= S_ERROR;
          end else if (r_argc == MAX_ARGS_C) begin
            r_error <= ERR_ARGC;
            r_done  <= 1'b1;
            r_state <= S_ERROR;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= ptr_of(r_rdata);
            r_cont     <= S_ACCUM;
            r_tmo      <= '0;
            r_state    <= S_MEM_WAIT;
          end
        end
        S_ACCUM: begin
          r_acc      <= w_acc_next;
          r_argc     <= r_argc + 1'b1;
          r_mem_req  <= 1'b1;
          r_mem_addr <= r_list + 1'b1;
          r_cont     <= S_LIST_STEP;
          r_tmo      <= '0;
          r_state    <= S_MEM_WAIT;
        end
        S_DONE, S_ERROR: r_state <= S_IDLE;
        default:         r_state <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_req  = r_mem_req;
  assign mem.mem_addr = r_mem_addr;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign val          = r_val;
  assign error        = r_error;
  assign state_dbg    = r_state;

endmodule
